// File: rtl/pc_gen_pkg.sv
// pc_pkg: shared types and helpers for the fetch-side program-counter unit.
package pc_pkg;

  // Fetch-unit control states
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  // Where the next PC comes from, listed highest priority first
  typedef enum logic [1:0] {
    SRC_TRAP  = 2'd0,
    SRC_REDIR = 2'd1,
    SRC_SEQ   = 2'd2,
    SRC_HOLD  = 2'd3
  } pc_src_t;

  // True when step is a non-zero power of two
  function automatic logic step_is_pow2(input int unsigned step);
    return (step != 0) && ((step & (step - 1)) == 0);
  endfunction

  // Low-bit mask that must be zero for an address aligned to step bytes
  function automatic logic [63:0] align_mask(input int unsigned step);
    return 64'(step) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_gen_next_sel.sv
// pc_next_sel: combinational priority select for the next program counter.
// Reports which source wins this cycle and whether that winner's target is
// misaligned; the caller owns all registers and state transitions.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  pc_state_t       state_i,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  output pc_src_t         src_o,
  output logic            misaligned_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(STEP));

  // A non power-of-two step would make the alignment mask meaningless
  if (!step_is_pow2(STEP)) begin : g_bad_step
    $error("pc_next_sel: STEP must be a power of two");
  end

  logic trapMis;
  logic redirMis;

  assign trapMis  = (trap_vector_i & ALIGN_MASK) != '0;
  assign redirMis = (redirect_pc_i & ALIGN_MASK) != '0;

  // Pick the winning source for the current state and flag only its target
  always_comb begin
    src_o        = SRC_HOLD;
    misaligned_o = 1'b0;
    case (state_i)
      RUN: begin
        if (trap_valid_i) begin
          src_o        = SRC_TRAP;
          misaligned_o = trapMis;
        end else if (redirect_valid_i) begin
          src_o        = SRC_REDIR;
          misaligned_o = redirMis;
        end else if (fetch_ready_i && !stall_i) begin
          src_o = SRC_SEQ;
        end
      end
      HALTED: begin
        if (trap_valid_i) begin
          src_o        = SRC_TRAP;
          misaligned_o = trapMis;
        end
      end
      default: begin
        src_o        = SRC_HOLD;
        misaligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-side program counter with prioritised next-PC selection,
// valid/ready handshake to instruction memory, halt/resume control,
// sticky misalignment flag and an accepted-fetch counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     STEP     = 4,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  fetch_pc,
  output logic [XLEN-1:0]  pc_plus_step,
  output logic             misalign_fault,
  output logic [CNT_W-1:0] fetch_cnt
);

  pc_state_t        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  pc_src_t          src;
  logic             misaligned;
  logic [XLEN-1:0]  pcSeq;

  assign pcSeq = pc_q + XLEN'(STEP);

  pc_next_sel #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_next_sel (
    .state_i          (state_q),
    .stall_i          (stall),
    .fetch_ready_i    (fetch_ready),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .trap_valid_i     (trap_valid),
    .trap_vector_i    (trap_vector),
    .src_o            (src),
    .misaligned_o     (misaligned)
  );

  // Next-state logic: FSM transitions, PC load and sticky fault handling
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (misaligned) begin
          fault_d = 1'b1;
          state_d = HALTED;
        end else begin
          case (src)
            SRC_TRAP:  pc_d = trap_vector;
            SRC_REDIR: pc_d = redirect_pc;
            SRC_SEQ:   pc_d = pcSeq;
            default:   pc_d = pc_q;
          endcase
          if (halt_req && (src != SRC_TRAP)) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        if (src == SRC_TRAP) begin
          if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            pc_d    = trap_vector;
            fault_d = 1'b0;
            state_d = RUN;
          end
        end else if (resume) begin
          fault_d = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    valid_d = (state_d == RUN);
    cnt_d   = cnt_q + CNT_W'(valid_q && fetch_ready);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_valid    = valid_q;
  assign fetch_pc       = pc_q;
  assign pc_plus_step   = pcSeq;
  assign misalign_fault = fault_q;
  assign fetch_cnt      = cnt_q;

endmodule
